sound_arbiter: RTL and testbench

//  Shares the single synthesizer key-code input between N_SRC demo song players and the live
//  PS/2 keyboard. Grants one player at a time (round-robin), inserts a silent guard gap between

---
 rtl/sound_arbiter_pkg.sv | 30 +++
 rtl/sound_arbiter_if.sv | 29 ++
 rtl/sound_arbiter_rr_pick.sv | 39 +++
 rtl/sound_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sound_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/sound_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sound_pkg
// Brief   : Shared constants, FSM encoding and helpers for the sound arbiter.
// Revision: 1.0
// ============================================================================
package sound_pkg;

   localparam logic [7:0] KEY_BREAK  = 8'hf0;
   localparam int         SEL_W      = 3;
   localparam logic [3:0] OWNER_IDLE = 4'h0;
   localparam logic [3:0] OWNER_LIVE = 4'h8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GUARD = 2'd1,
      PLAY  = 2'd2,
      LIVE  = 2'd3
   } state_e;

   function automatic logic [3:0] owner_of(input logic [SEL_W-1:0] sel);
      return {1'b0, sel};
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hffff) ? v : v + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sound_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : sound_arbiter_if
// Brief   : Player/keyboard/synth signal bundle of the sound arbiter.
// Revision: 1.0
// ============================================================================
interface sound_arbiter_if #(
   parameter int N_SRC = 4
) ();
   logic [7:0]         live_code;
   logic [N_SRC-1:0]   src_req;
   logic [8*N_SRC-1:0] src_code;
   logic [N_SRC-1:0]   src_done;
   logic [N_SRC-1:0]   src_grant;
   logic [7:0]         key_code;
   logic [3:0]         owner;
   logic               busy;

   modport master (
      output live_code, src_req, src_code, src_done,
      input  src_grant, key_code, owner, busy
   );

   modport slave (
      input  live_code, src_req, src_code, src_done,
      output src_grant, key_code, owner, busy
   );
endinterface
`default_nettype wire

// File: rtl/sound_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker: first requester at or after ptr.
// Revision: 1.0
// ============================================================================
module rr_pick
   import sound_pkg::*;
#(
   parameter int N = 4
) (
   input  wire logic [N-1:0]     req,
   input  wire logic [SEL_W-1:0] ptr,
   output logic      [SEL_W-1:0] sel,
   output logic                  valid
);

   logic [N-1:0] w_rot;

   // Rotating a doubled copy puts the requester at ptr into bit 0.
   assign w_rot = N'({req, req} >> ptr);

   always_comb begin
      int s;
      s     = 0;
      sel   = '0;
      valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!valid && w_rot[k]) begin
            valid = 1'b1;
            s     = int'(ptr) + k;
            if (s >= N) s = s - N;
            sel   = SEL_W'(s);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sound_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sound_arbiter
// Brief   : Round-robin owner of the synth key code between song players and
//           the live keyboard, with guard gaps and note-boundary preemption.
// Revision: 1.0
// ============================================================================
module sound_arbiter
   import sound_pkg::*;
#(
   parameter int          N_SRC       = 4,
   parameter logic [15:0] GUARD_CYC   = 16'h10,
   parameter logic [15:0] PREEMPT_CYC = 16'h400
) (
   input  wire logic       clock,
   input  wire logic       k_tr,
   sound_arbiter_if.slave  bus
);

   localparam logic [15:0] c_guard_last   = GUARD_CYC - 16'd1;
   localparam logic [15:0] c_preempt_last = PREEMPT_CYC - 16'd1;

   state_e           r_state;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] r_ptr;
   logic [15:0]      r_cnt;
   logic [15:0]      r_wait;
   logic [7:0]       r_key;
   logic [N_SRC-1:0] r_grant;
   logic [3:0]       r_owner;
   logic             r_busy;

   logic [SEL_W-1:0] w_pick_sel;
   logic             w_pick_valid;
   logic             w_live;
   logic [7:0]       w_src_code;
   logic             w_req_sel;
   logic             w_done_sel;
   logic [N_SRC-1:0] w_onehot;
   logic [SEL_W-1:0] w_ptr_next;

   rr_pick #(.N(N_SRC)) u_pick (
      .req   (bus.src_req),
      .ptr   (r_ptr),
      .sel   (w_pick_sel),
      .valid (w_pick_valid)
   );

   assign w_live     = (bus.live_code != KEY_BREAK);
   assign w_onehot   = N_SRC'(1) << r_sel;
   assign w_ptr_next = (r_sel == SEL_W'(N_SRC - 1)) ? '0 : r_sel + SEL_W'(1);

   // Constant-index mux so unselected player inputs never leak through.
   always_comb begin
      w_src_code = KEY_BREAK;
      w_req_sel  = 1'b0;
      w_done_sel = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (r_sel == SEL_W'(i)) begin
            w_src_code = bus.src_code[8*i +: 8];
            w_req_sel  = bus.src_req[i];
            w_done_sel = bus.src_done[i];
         end
      end
   end

   always_ff @(posedge clock or negedge k_tr) begin
      if (!k_tr) begin
         r_state <= IDLE;
         r_sel   <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_wait  <= '0;
         r_key   <= KEY_BREAK;
         r_grant <= '0;
         r_owner <= OWNER_IDLE;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_key   <= KEY_BREAK;
               r_grant <= '0;
               if (w_live) begin
                  r_state <= LIVE;
                  r_cnt   <= '0;
                  r_key   <= bus.live_code;
                  r_owner <= OWNER_LIVE;
                  r_busy  <= 1'b1;
               end else if (w_pick_valid) begin
                  r_state <= GUARD;
                  r_sel   <= w_pick_sel;
                  r_cnt   <= '0;
                  r_owner <= owner_of(w_pick_sel);
                  r_busy  <= 1'b1;
               end
            end
            GUARD: begin
               r_key <= KEY_BREAK;
               if (w_live) begin
                  r_state <= LIVE;
                  r_cnt   <= '0;
                  r_key   <= bus.live_code;
                  r_owner <= OWNER_LIVE;
               end else if (!w_req_sel) begin
                  r_state <= IDLE;
                  r_owner <= OWNER_IDLE;
                  r_busy  <= 1'b0;
               end else if (r_cnt == c_guard_last) begin
                  // Key stays silent this edge: the player is only now leaving reset.
                  r_state <= PLAY;
                  r_grant <= w_onehot;
                  r_wait  <= '0;
               end else begin
                  r_cnt <= sat_inc(r_cnt);
               end
            end
            PLAY: begin
               if (w_done_sel || !w_req_sel) begin
                  r_state <= IDLE;
                  r_grant <= '0;
                  r_ptr   <= w_ptr_next;
                  r_key   <= KEY_BREAK;
                  r_owner <= OWNER_IDLE;
                  r_busy  <= 1'b0;
               end else if (w_live && (w_src_code == KEY_BREAK || r_wait == c_preempt_last)) begin
                  r_state <= LIVE;
                  r_grant <= '0;
                  r_ptr   <= w_ptr_next;
                  r_cnt   <= '0;
                  r_key   <= bus.live_code;
                  r_owner <= OWNER_LIVE;
               end else begin
                  r_key  <= w_src_code;
                  r_wait <= w_live ? sat_inc(r_wait) : '0;
               end
            end
            LIVE: begin
               r_key   <= bus.live_code;
               r_grant <= '0;
               if (w_live) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_guard_last) begin
                  r_state <= IDLE;
                  r_owner <= OWNER_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= sat_inc(r_cnt);
               end
            end
            default: begin
               r_state <= IDLE;
               r_key   <= KEY_BREAK;
               r_grant <= '0;
               r_owner <= OWNER_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.src_grant = r_grant;
   assign bus.key_code  = r_key;
   assign bus.owner     = r_owner;
   assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sound_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sound_arbiter
// Brief   : Scoreboard bench: stimulus queues expected output changes with
//           their cycle stamps, a monitor pops them as the outputs change.
// Revision: 1.0
// ============================================================================
module tb_sound_arbiter;

   typedef struct {
      int         cyc;
      logic [7:0] key;
      logic [3:0] grant;
      logic [3:0] owner;
      logic       busy;
   } exp_t;

   logic       clock = 1'b0;
   logic       k_tr  = 1'b0;
   int         cyc   = 0;
   int         checks = 0;
   int         errors = 0;
   exp_t       exp_q[$];
   logic [7:0] codes[4];

   sound_arbiter_if #(.N_SRC(4)) intf ();

   assign intf.src_code = {codes[3], codes[2], codes[1], codes[0]};

   sound_arbiter #(
      .N_SRC       (4),
      .GUARD_CYC   (16'h10),
      .PREEMPT_CYC (16'h400)
   ) dut (
      .clock (clock),
      .k_tr  (k_tr),
      .bus   (intf.slave)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic expect_at(input int c, input logic [7:0] k, input logic [3:0] g,
                            input logic [3:0] o, input logic b);
      exp_t e;
      e.cyc = c; e.key = k; e.grant = g; e.owner = o; e.busy = b;
      exp_q.push_back(e);
   endtask

   task automatic check_now(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every change of the output tuple must match the next queued entry.
   initial begin
      logic [16:0] last, cur;
      exp_t e;
      @(posedge k_tr);
      last = {8'hf0, 4'h0, 4'h0, 1'b0};
      forever begin
         @(negedge clock);
         checks++;
         if (!$onehot0(intf.src_grant) ||
             (intf.src_grant != 4'h0 && (intf.owner[3] || !intf.busy))) begin
            errors++;
            $display("FAIL grant_onehot cyc=%0d grant=%b owner=%h busy=%b",
                     cyc, intf.src_grant, intf.owner, intf.busy);
         end
         cur = {intf.key_code, intf.src_grant, intf.owner, intf.busy};
         if (cur !== last) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change cyc=%0d actual key=%h grant=%b owner=%h busy=%b",
                        cyc, intf.key_code, intf.src_grant, intf.owner, intf.busy);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || cur !== {e.key, e.grant, e.owner, e.busy}) begin
                  errors++;
                  $display("FAIL out_change actual cyc=%0d key=%h grant=%b owner=%h busy=%b required cyc=%0d key=%h grant=%b owner=%h busy=%b",
                           cyc, intf.key_code, intf.src_grant, intf.owner, intf.busy,
                           e.cyc, e.key, e.grant, e.owner, e.busy);
               end
            end
            last = cur;
         end
      end
   end

   initial begin
      int c;
      intf.live_code = 8'hf0;
      intf.src_req   = 4'b0000;
      intf.src_done  = 4'b0000;
      codes[0] = 8'h21; codes[1] = 8'h2b; codes[2] = 8'h45; codes[3] = 8'h34;

      step(3);
      check_now("reset_key",   {8'h0, intf.key_code},  16'h00f0);
      check_now("reset_grant", {12'h0, intf.src_grant}, 16'h0000);
      check_now("reset_owner", {12'h0, intf.owner},     16'h0000);
      check_now("reset_busy",  {15'h0, intf.busy},      16'h0000);
      k_tr = 1'b1;
      step(2);

      // Round robin 0 then 2 with guard gaps
      c = cyc; intf.src_req = 4'b0101;
      expect_at(c+1,  8'hf0, 4'b0000, 4'h0, 1'b1);
      expect_at(c+17, 8'hf0, 4'b0001, 4'h0, 1'b1);
      expect_at(c+18, 8'h21, 4'b0001, 4'h0, 1'b1);
      step(22);
      c = cyc; intf.src_done = 4'b0001; intf.src_req = 4'b0100;
      expect_at(c+1,  8'hf0, 4'b0000, 4'h0, 1'b0);
      step(1);
      c = cyc; intf.src_done = 4'b0000;
      expect_at(c+1,  8'hf0, 4'b0000, 4'h2, 1'b1);
      expect_at(c+17, 8'hf0, 4'b0100, 4'h2, 1'b1);
      expect_at(c+18, 8'h45, 4'b0100, 4'h2, 1'b1);
      step(20);
      c = cyc; codes[2] = 8'h46;
      expect_at(c+1,  8'h46, 4'b0100, 4'h2, 1'b1);
      step(3);
      c = cyc; intf.src_req = 4'b0000;
      expect_at(c+1,  8'hf0, 4'b0000, 4'h0, 1'b0);

      // Request withdrawn during guard
      step(2);
      c = cyc; intf.src_req = 4'b0001;
      expect_at(c+1,  8'hf0, 4'b0000, 4'h0, 1'b1);
      step(5);
      c = cyc; intf.src_req = 4'b0000;
      expect_at(c+1,  8'hf0, 4'b0000, 4'h0, 1'b0);

      // Live key waits for player 1's note boundary
      step(2);
      c = cyc; intf.src_req = 4'b0010;
      expect_at(c+1,  8'hf0, 4'b0000, 4'h1, 1'b1);
      expect_at(c+17, 8'hf0, 4'b0010, 4'h1, 1'b1);
      expect_at(c+18, 8'h2b, 4'b0010, 4'h1, 1'b1);
      step(20);
      intf.live_code = 8'h52;
      step(5);
      c = cyc; codes[1] = 8'hf0;
      expect_at(c+1,  8'h52, 4'b0000, 4'h8, 1'b1);

      // Live silence: 15 cycles keeps LIVE, 16 returns to IDLE
      step(3);
      c = cyc; intf.live_code = 8'hf0; intf.src_req = 4'b0000;
      expect_at(c+1,  8'hf0, 4'b0000, 4'h8, 1'b1);
      step(15);
      c = cyc; intf.live_code = 8'h33;
      expect_at(c+1,  8'h33, 4'b0000, 4'h8, 1'b1);
      step(1);
      c = cyc; intf.live_code = 8'hf0;
      expect_at(c+1,  8'hf0, 4'b0000, 4'h8, 1'b1);
      expect_at(c+16, 8'hf0, 4'b0000, 4'h0, 1'b0);

      // Sustained note: forced preemption after PREEMPT_CYC cycles
      step(20);
      c = cyc; codes[1] = 8'h2b; intf.src_req = 4'b1000;
      expect_at(c+1,  8'hf0, 4'b0000, 4'h3, 1'b1);
      expect_at(c+17, 8'hf0, 4'b1000, 4'h3, 1'b1);
      expect_at(c+18, 8'h34, 4'b1000, 4'h3, 1'b1);
      step(20);
      c = cyc; intf.live_code = 8'h5a;
      expect_at(c+1024, 8'h5a, 4'b0000, 4'h8, 1'b1);
      step(1030);
      c = cyc; intf.live_code = 8'hf0; intf.src_req = 4'b0000;
      expect_at(c+1,  8'hf0, 4'b0000, 4'h8, 1'b1);
      expect_at(c+16, 8'hf0, 4'b0000, 4'h0, 1'b0);

      // Live and request together in IDLE: live wins
      step(20);
      c = cyc; intf.live_code = 8'h66; intf.src_req = 4'b0001;
      expect_at(c+1,  8'h66, 4'b0000, 4'h8, 1'b1);
      step(6);
      c = cyc; intf.live_code = 8'hf0; intf.src_req = 4'b0000;
      expect_at(c+1,  8'hf0, 4'b0000, 4'h8, 1'b1);
      expect_at(c+16, 8'hf0, 4'b0000, 4'h0, 1'b0);

      // Asynchronous reset in the middle of a note
      step(20);
      c = cyc; intf.src_req = 4'b0100;
      expect_at(c+1,  8'hf0, 4'b0000, 4'h2, 1'b1);
      expect_at(c+17, 8'hf0, 4'b0100, 4'h2, 1'b1);
      expect_at(c+18, 8'h46, 4'b0100, 4'h2, 1'b1);
      step(20);
      c = cyc;
      #2 k_tr = 1'b0;
      #1;
      check_now("async_key",   {8'h0, intf.key_code},  16'h00f0);
      check_now("async_grant", {12'h0, intf.src_grant}, 16'h0000);
      check_now("async_busy",  {15'h0, intf.busy},      16'h0000);
      expect_at(c+1,  8'hf0, 4'b0000, 4'h0, 1'b0);
      step(3);
      intf.src_req = 4'b0000;
      k_tr = 1'b1;
      step(5);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events actual=%0d required=0", exp_q.size());
         while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("  missing change at cyc=%0d key=%h grant=%b owner=%h busy=%b",
                     e.cyc, e.key, e.grant, e.owner, e.busy);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
